// File: rtl/coco_ram_arbiter.sv
// Time-slot arbiter for the shared CoCo system RAM port: VDG in slot 0, CPU in slot 2,
// loader DMA write FIFO in slots 1/3 and any free slot. DMA path present only with COCO_RAM_ARB_DMA_EN.
module coco_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              cpu_ram_cs,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_rdata,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [7:0]        vdg_data,
  output logic              vdg_valid,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_data,
  output logic              dma_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    SLOT_VDG   = 2'd0,
    SLOT_DMA_A = 2'd1,
    SLOT_CPU   = 2'd2,
    SLOT_DMA_B = 2'd3
  } slot_t;

  slot_t slot, slot_nxt;

  logic              fifo_nonempty;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;
  logic              dma_pop;
  logic              issue_cpu_rd;
  logic              issue_vdg_rd;
  logic              rd_pend_cpu;
  logic              rd_pend_vdg;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) slot <= SLOT_VDG;
    else       slot <= slot_nxt;
  end

  always_comb begin
    slot_nxt = slot;
    if (clk_ena) begin
      unique case (slot)
        SLOT_VDG:   slot_nxt = SLOT_DMA_A;
        SLOT_DMA_A: slot_nxt = SLOT_CPU;
        SLOT_CPU:   slot_nxt = SLOT_DMA_B;
        default:    slot_nxt = SLOT_VDG;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    issue_cpu_rd = 1'b0;
    issue_vdg_rd = 1'b0;
    dma_pop      = 1'b0;
    // The RAM port is driven only in the issue clk; reset masks it so nothing retires mid-reset.
    if (clk_ena && !reset) begin
      if (slot == SLOT_VDG && vdg_req) begin
        ram_en       = 1'b1;
        ram_addr     = vdg_addr;
        issue_vdg_rd = 1'b1;
      end else if (slot == SLOT_CPU && cpu_ram_cs) begin
        ram_en   = 1'b1;
        ram_addr = cpu_addr;
        if (!cpu_rw) begin
          ram_we  = 1'b1;
          ram_din = cpu_dout;
        end else begin
          issue_cpu_rd = 1'b1;
        end
      end else if (fifo_nonempty) begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = head_addr;
        ram_din  = head_data;
        dma_pop  = 1'b1;
      end
    end
  end

  // ram_q is valid the clk after issue; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_cpu <= 1'b0;
      rd_pend_vdg <= 1'b0;
      cpu_rdata   <= 8'h00;
      vdg_data    <= 8'h00;
      vdg_valid   <= 1'b0;
    end else begin
      rd_pend_cpu <= issue_cpu_rd;
      rd_pend_vdg <= issue_vdg_rd;
      vdg_valid   <= rd_pend_vdg;
      if (rd_pend_cpu) cpu_rdata <= ram_q;
      if (rd_pend_vdg) vdg_data  <= ram_q;
    end
  end

`ifdef COCO_RAM_ARB_DMA_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              dma_push;

  assign dma_ready     = !reset && (fifo_count < DEPTH_CNT);
  assign dma_push      = dma_wr && dma_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];

  // NOTE: FIFO storage is not reset; the cleared count alone marks its contents as invalid.
  always_ff @(posedge clk) begin
    if (dma_push) begin
      fifo_addr[wr_ptr] <= dma_addr;
      fifo_data[wr_ptr] <= dma_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (dma_push) wr_ptr <= wr_ptr + 1'b1;
      if (dma_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({dma_push, dma_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
`else
  assign dma_ready     = 1'b0;
  assign fifo_nonempty = 1'b0;
  assign head_addr     = '0;
  assign head_data     = '0;

  wire unused_dma = ^{dma_wr, dma_addr, dma_data, dma_pop};
`endif

endmodule
